// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter
// Shares the single-ported simulation RAM between the instruction fetch
// port (IFU) and the load/store port (LSU). Each accepted request takes
// exactly three cycles: IDLE (grant), ACCESS (RAM cycle), RESP (rvalid).
// The RAM is addressed in 64-bit words relative to PC_START. Store data and
// byte masks are shifted into their lanes. Load data is shifted down and
// zero-extended.
//
// Optional feature: define RAM_UART_MMIO_EN to decode LSU accesses to
// UART_ADDR as a UART TX register instead of RAM.
//
// Ports
//   clock, reset                      clock, synchronous active-high reset
//   ifu_req_i/addr_i                  fetch request, held until granted
//   ifu_gnt_o/rvalid_o/rdata_o        fetch grant, response pulse, instruction
//   lsu_req_i/wen_i/addr_i/wdata_i/size_i  load/store request
//   lsu_gnt_o/rvalid_o/rdata_o        load/store grant, response pulse, load data
//   ram_en_o/idx_o/wen_o/wdata_o/wmask_o   RAMHelper request side
//   ram_rdata_i                       RAMHelper read data (combinational on idx)
//   uart_valid_o/uart_ch_o            UART character strobe and character
module ram_bus_arbiter #(
    parameter logic [63:0] PC_START  = 64'h8000_0000,
    parameter int          IDX_W     = 16,
    parameter logic [63:0] UART_ADDR = 64'h1000_0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ifu_req_i,
    input  logic [63:0]      ifu_addr_i,
    output logic             ifu_gnt_o,
    output logic             ifu_rvalid_o,
    output logic [31:0]      ifu_rdata_o,
    input  logic             lsu_req_i,
    input  logic             lsu_wen_i,
    input  logic [63:0]      lsu_addr_i,
    input  logic [63:0]      lsu_wdata_i,
    input  logic [1:0]       lsu_size_i,
    output logic             lsu_gnt_o,
    output logic             lsu_rvalid_o,
    output logic [63:0]      lsu_rdata_o,
    output logic             ram_en_o,
    output logic [IDX_W-1:0] ram_idx_o,
    output logic             ram_wen_o,
    output logic [63:0]      ram_wdata_o,
    output logic [63:0]      ram_wmask_o,
    input  logic [63:0]      ram_rdata_i,
    output logic             uart_valid_o,
    output logic [7:0]       uart_ch_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        rr_q, rr_d;              // 1: IFU wins the next tie
    logic        owner_lsu_q, owner_lsu_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        wen_q, wen_d;
    logic [63:0] rdata_q, rdata_d;

    logic in_idle, in_access, in_resp;
    logic grant_lsu, grant_ifu;
    logic uart_hit;

    // Reset gates every control output, so a stale state never leaks out
    // during a reset cycle.
    assign in_idle   = (state_q == ST_IDLE)   && !reset;
    assign in_access = (state_q == ST_ACCESS) && !reset;
    assign in_resp   = (state_q == ST_RESP)   && !reset;

    // LSU wins a tie unless the previous grant went to the LSU.
    assign grant_lsu = in_idle && lsu_req_i && (!ifu_req_i || !rr_q);
    assign grant_ifu = in_idle && ifu_req_i && !grant_lsu;
    assign lsu_gnt_o = grant_lsu;
    assign ifu_gnt_o = grant_ifu;

    // ---------------- address and lane datapath ----------------
    logic [63:0] idx_full;
    logic [2:0]  off;
    logic [5:0]  shift_bits;
    logic [3:0]  nbytes;
    logic [15:0] lane_run, lane_wide;
    logic [7:0]  byte_mask;
    logic [63:0] wmask_full, wdata_aligned, size_mask, load_data;
    logic [31:0] fetch_data;
    logic        unused_addr_bits;

    assign idx_full         = (addr_q - PC_START) >> 3;   // wraps on underflow
    assign unused_addr_bits = ^{idx_full[63:IDX_W], lane_wide[15:8]};
    assign off              = addr_q[2:0];
    assign shift_bits       = {off, 3'b000};

    // Lanes shifted past byte 7 are dropped by taking only the low byte.
    assign nbytes        = 4'd1 << size_q;
    assign lane_run      = (16'd1 << nbytes) - 16'd1;
    assign lane_wide     = lane_run << off;
    assign byte_mask     = lane_wide[7:0];
    assign wdata_aligned = wdata_q << shift_bits;

    always_comb begin
        wmask_full = '0;
        for (int i = 0; i < 8; i++) begin
            wmask_full[i*8 +: 8] = {8{byte_mask[i]}};
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign load_data  = (ram_rdata_i >> shift_bits) & size_mask;
    assign fetch_data = addr_q[2] ? ram_rdata_i[63:32] : ram_rdata_i[31:0];

`ifdef RAM_UART_MMIO_EN
    assign uart_hit     = owner_lsu_q && (addr_q == UART_ADDR);
    assign uart_valid_o = in_access && uart_hit && wen_q;
    assign uart_ch_o    = uart_valid_o ? wdata_q[7:0] : 8'd0;
`else
    assign uart_hit     = 1'b0;
    assign uart_valid_o = 1'b0;
    assign uart_ch_o    = 8'd0;
`endif

    // ---------------- RAM and response outputs ----------------
    assign ram_en_o    = in_access && !uart_hit;
    assign ram_wen_o   = ram_en_o && wen_q;
    assign ram_idx_o   = ram_en_o  ? idx_full[IDX_W-1:0] : '0;
    assign ram_wdata_o = ram_wen_o ? wdata_aligned : 64'd0;
    assign ram_wmask_o = ram_wen_o ? wmask_full : 64'd0;

    assign lsu_rvalid_o = in_resp && owner_lsu_q;
    assign ifu_rvalid_o = in_resp && !owner_lsu_q;
    assign lsu_rdata_o  = lsu_rvalid_o ? rdata_q : 64'd0;
    assign ifu_rdata_o  = ifu_rvalid_o ? rdata_q[31:0] : 32'd0;

    // ---------------- next state ----------------
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_lsu_d = owner_lsu_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        wen_d       = wen_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_lsu) begin
                    state_d     = ST_ACCESS;
                    rr_d        = 1'b1;
                    owner_lsu_d = 1'b1;
                    addr_d      = lsu_addr_i;
                    wdata_d     = lsu_wdata_i;
                    size_d      = lsu_size_i;
                    wen_d       = lsu_wen_i;
                end else if (grant_ifu) begin
                    state_d     = ST_ACCESS;
                    rr_d        = 1'b0;
                    owner_lsu_d = 1'b0;
                    addr_d      = ifu_addr_i;
                    wdata_d     = 64'd0;
                    size_d      = 2'd2;
                    wen_d       = 1'b0;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (!owner_lsu_q)            rdata_d = {32'd0, fetch_data};
                else if (wen_q || uart_hit)  rdata_d = 64'd0;
                else                         rdata_d = load_data;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register update in this block
    // seeing the pre-edge values; the reset is synchronous, so it sits inside
    // the clocked branch rather than in the sensitivity list.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            owner_lsu_q <= 1'b0;
            addr_q      <= 64'd0;
            wdata_q     <= 64'd0;
            size_q      <= 2'd0;
            wen_q       <= 1'b0;
            rdata_q     <= 64'd0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_lsu_q <= owner_lsu_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            wen_q       <= wen_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter. Responses are checked by a
// scoreboard: the expected owner, data and arrival cycle are queued when a
// grant is seen, and popped when an rvalid pulse appears.
module tb_ram_bus_arbiter;

    localparam logic [63:0] R = 64'h1122_3344_5566_7788;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req, lsu_req, lsu_wen;
    logic [63:0] ifu_addr, lsu_addr, lsu_wdata, ram_rdata;
    logic [1:0]  lsu_size;
    logic        ifu_gnt_o, ifu_rvalid_o, lsu_gnt_o, lsu_rvalid_o;
    logic [31:0] ifu_rdata_o;
    logic [63:0] lsu_rdata_o;
    logic        ram_en_o, ram_wen_o, uart_valid_o;
    logic [15:0] ram_idx_o;
    logic [63:0] ram_wdata_o, ram_wmask_o;
    logic [7:0]  uart_ch_o;

    ram_bus_arbiter dut (
        .clock(clock), .reset(reset),
        .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_gnt_o(ifu_gnt_o),
        .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
        .lsu_req_i(lsu_req), .lsu_wen_i(lsu_wen), .lsu_addr_i(lsu_addr),
        .lsu_wdata_i(lsu_wdata), .lsu_size_i(lsu_size), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .ram_en_o(ram_en_o), .ram_idx_o(ram_idx_o), .ram_wen_o(ram_wen_o),
        .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o),
        .ram_rdata_i(ram_rdata),
        .uart_valid_o(uart_valid_o), .uart_ch_o(uart_ch_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        lsu;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Response monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (ifu_rvalid_o || lsu_rvalid_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: ifu_rvalid=%b lsu_rvalid=%b at cycle %0d, required none",
                         ifu_rvalid_o, lsu_rvalid_o, cyc);
            end else begin
                exp_t        e;
                logic [63:0] got;
                e   = sb.pop_front();
                got = e.lsu ? lsu_rdata_o : {32'd0, ifu_rdata_o};
                if ({ifu_rvalid_o, lsu_rvalid_o} !== {!e.lsu, e.lsu} || got !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL response: rvalid(ifu,lsu)=%b%b data=%h cycle=%0d, required %b%b data=%h cycle=%0d",
                             ifu_rvalid_o, lsu_rvalid_o, got, cyc, !e.lsu, e.lsu, e.data, e.cyc);
                end
            end
        end
    end

    // One complete request: grant, ACCESS-cycle RAM/UART check, response.
    // Entered and left at posedge+1 of an IDLE cycle.
    task automatic issue(input string name, input logic is_lsu, input logic wen,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [1:0] size,
                         input logic [63:0] rdata, input logic exp_en, input logic [15:0] exp_idx,
                         input logic [63:0] exp_wdata, input logic [63:0] exp_wmask,
                         input logic exp_uv, input logic [7:0] exp_uc, input logic [63:0] exp_resp);
        int          n;
        logic [154:0] act, exp;
        ram_rdata = rdata;
        if (is_lsu) begin
            lsu_req = 1'b1; lsu_wen = wen; lsu_addr = addr; lsu_wdata = wdata; lsu_size = size;
        end else begin
            ifu_req = 1'b1; ifu_addr = addr;
        end
        #1;
        n = 0;
        while (!(is_lsu ? lsu_gnt_o : ifu_gnt_o) && n < 20) begin
            @(posedge clock); #2; n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL %s grant: no grant within 20 cycles, required grant", name);
            lsu_req = 1'b0; ifu_req = 1'b0;
            @(posedge clock); #1;
            return;
        end
        sb.push_back('{lsu: is_lsu, data: exp_resp, cyc: cyc + 2});
        @(posedge clock); #1;
        lsu_req = 1'b0; ifu_req = 1'b0;
        #1;
        // Write data and mask only matter for stores.
        act = {ram_en_o, ram_idx_o, ram_wen_o, wen ? ram_wdata_o : 64'd0,
               wen ? ram_wmask_o : 64'd0, uart_valid_o, uart_ch_o};
        exp = {exp_en, exp_idx, exp_en && wen, wen ? exp_wdata : 64'd0,
               wen ? exp_wmask : 64'd0, exp_uv, exp_uc};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s access: en=%b idx=%h wen=%b wdata=%h wmask=%h uart=%b/%h, required en=%b idx=%h wen=%b wdata=%h wmask=%h uart=%b/%h",
                     name, ram_en_o, ram_idx_o, ram_wen_o, ram_wdata_o, ram_wmask_o, uart_valid_o, uart_ch_o,
                     exp_en, exp_idx, exp_en && wen, exp_wdata, exp_wmask, exp_uv, exp_uc);
        end
        @(posedge clock); #1;   // RESP
        @(posedge clock); #1;   // back in IDLE
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s missing_response: %0d pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #2;
            checks++;
            if ({ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, ram_en_o,
                 ram_idx_o, ram_wen_o, ram_wdata_o, ram_wmask_o, uart_valid_o, uart_ch_o} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: gnt=%b%b en=%b wen=%b idx=%h rvalid=%b%b, required all 0",
                         ifu_gnt_o, lsu_gnt_o, ram_en_o, ram_wen_o, ram_idx_o, ifu_rvalid_o, lsu_rvalid_o);
            end
        end
    endtask

    // Both masters held through reset: LSU, IFU, LSU, IFU three cycles apart.
    task automatic test_back_to_back();
        logic [1:0] exp_g;
        ram_rdata = R;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin @(posedge clock); #2; end
            exp_g = (c % 6 == 0) ? 2'b10 : (c % 6 == 3) ? 2'b01 : 2'b00;
            checks++;
            if ({lsu_gnt_o, ifu_gnt_o} !== exp_g) begin
                errors++;
                $display("FAIL back_to_back c=%0d: gnt(lsu,ifu)=%b%b, required %b", c, lsu_gnt_o, ifu_gnt_o, exp_g);
            end
            if (exp_g == 2'b10) sb.push_back('{lsu: 1'b1, data: R, cyc: cyc + 2});
            if (exp_g == 2'b01) sb.push_back('{lsu: 1'b0, data: 64'h0000_0000_1122_3344, cyc: cyc + 2});
        end
        lsu_req = 1'b0; ifu_req = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back missing_response: %0d pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_fetch();
        issue("fetch_hi", 1'b0, 1'b0, 64'h8000_0004, 64'd0, 2'd2, R,
              1'b1, 16'h0000, 64'd0, 64'd0, 1'b0, 8'h00, 64'h0000_0000_1122_3344);
        issue("fetch_lo", 1'b0, 1'b0, 64'h8000_0000, 64'd0, 2'd2, R,
              1'b1, 16'h0000, 64'd0, 64'd0, 1'b0, 8'h00, 64'h0000_0000_5566_7788);
    endtask

    task automatic test_store_align();
        issue("sb_off3", 1'b1, 1'b1, 64'h8000_0013, 64'hAB, 2'd0, R,
              1'b1, 16'h0002, 64'h0000_0000_AB00_0000, 64'h0000_0000_FF00_0000, 1'b0, 8'h00, 64'd0);
        issue("sd_off0", 1'b1, 1'b1, 64'h8000_0010, 64'h0102_0304_0506_0708, 2'd3, R,
              1'b1, 16'h0002, 64'h0102_0304_0506_0708, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'h00, 64'd0);
        issue("sw_off6_drop", 1'b1, 1'b1, 64'h8000_0016, 64'hDEAD_BEEF, 2'd2, R,
              1'b1, 16'h0002, 64'hBEEF_0000_0000_0000, 64'hFFFF_0000_0000_0000, 1'b0, 8'h00, 64'd0);
        issue("sh_off7_drop", 1'b1, 1'b1, 64'h8000_001F, 64'h1234, 2'd1, R,
              1'b1, 16'h0003, 64'h3400_0000_0000_0000, 64'hFF00_0000_0000_0000, 1'b0, 8'h00, 64'd0);
    endtask

    task automatic test_load_align();
        issue("lh_off2", 1'b1, 1'b0, 64'h8000_000A, 64'd0, 2'd1, R,
              1'b1, 16'h0001, 64'd0, 64'd0, 1'b0, 8'h00, 64'h0000_0000_0000_5566);
        issue("ld_off0", 1'b1, 1'b0, 64'h8000_0020, 64'd0, 2'd3, R,
              1'b1, 16'h0004, 64'd0, 64'd0, 1'b0, 8'h00, R);
        issue("lb_off7", 1'b1, 1'b0, 64'h8000_0027, 64'd0, 2'd0, R,
              1'b1, 16'h0004, 64'd0, 64'd0, 1'b0, 8'h00, 64'h0000_0000_0000_0011);
        issue("lw_off6", 1'b1, 1'b0, 64'h8000_0006, 64'd0, 2'd2, R,
              1'b1, 16'h0000, 64'd0, 64'd0, 1'b0, 8'h00, 64'h0000_0000_0000_1122);
    endtask

    task automatic test_index_wrap();
        issue("idx_underflow", 1'b1, 1'b0, 64'h7FFF_FFF8, 64'd0, 2'd3, R,
              1'b1, 16'hFFFF, 64'd0, 64'd0, 1'b0, 8'h00, R);
        issue("idx_truncate", 1'b1, 1'b0, 64'h8008_0000, 64'd0, 2'd3, R,
              1'b1, 16'h0000, 64'd0, 64'd0, 1'b0, 8'h00, R);
    endtask

    task automatic test_reset_mid_store();
        lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_0010; lsu_wdata = 64'h55; lsu_size = 2'd3;
        #1;
        checks++;
        if (lsu_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid grant: lsu_gnt=%b, required 1", lsu_gnt_o);
        end
        @(posedge clock); #1;
        lsu_req = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if ({ram_en_o, ram_wen_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid access: en=%b wen=%b, required 0 0", ram_en_o, ram_wen_o);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        // rr was left at 1 by the store; after reset the LSU must win again.
        ram_rdata = R;
        ifu_req = 1'b1; ifu_addr = 64'h8000_0000;
        lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_0000; lsu_size = 2'd3;
        #1;
        checks++;
        if ({lsu_gnt_o, ifu_gnt_o} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid regrant: gnt(lsu,ifu)=%b%b, required 10", lsu_gnt_o, ifu_gnt_o);
        end else begin
            sb.push_back('{lsu: 1'b1, data: R, cyc: cyc + 2});
        end
        @(posedge clock); #1;
        lsu_req = 1'b0; ifu_req = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid missing_response: %0d pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_uart();
`ifdef RAM_UART_MMIO_EN
        issue("uart_store", 1'b1, 1'b1, 64'h1000_0000, 64'h41, 2'd0, R,
              1'b0, 16'h0000, 64'd0, 64'd0, 1'b1, 8'h41, 64'd0);
        issue("uart_load", 1'b1, 1'b0, 64'h1000_0000, 64'd0, 2'd3, R,
              1'b0, 16'h0000, 64'd0, 64'd0, 1'b0, 8'h00, 64'd0);
`else
        issue("uart_addr_as_ram", 1'b1, 1'b1, 64'h1000_0000, 64'h41, 2'd0, R,
              1'b1, 16'h0000, 64'h41, 64'hFF, 1'b0, 8'h00, 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ifu_req = 1'b1; ifu_addr = 64'h8000_000C;
        lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_0008;
        lsu_wdata = 64'd0; lsu_size = 2'd3;
        ram_rdata = R;
        test_reset();
        test_back_to_back();
        test_fetch();
        test_store_align();
        test_load_align();
        test_index_wrap();
        test_reset_mid_store();
        test_uart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
